// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents: FSM state encoding, grant identifiers, default timeout.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side and memory-side handshake signals of the arbiter.
// Modports:
//   slave  - arbiter view: consumes requests and memory responses,
//            drives done/rdata/err and the memory request.
//   master - environment view (core plus memory model): the opposite directions.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_done;
    logic [31:0]           i_rdata;

    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_done;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  err;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_ready, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata, err,
               mem_req, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_ready, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata, err,
               mem_req, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin choice between fetch and data requests.
// Ports:
//   req_i, req_d  in  effective (already done-masked) requests
//   last_grant    in  requester that won the previous grant
//   gnt_i, gnt_d  out one-hot grant (both 0 when nothing requested)
module rr_arbiter2
    import rv_mem_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last_grant,
    output logic   gnt_i,
    output logic   gnt_d
);

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (req_i && req_d) begin
            // tie goes to whoever did not win last time
            if (last_grant == GNT_I) gnt_d = 1'b1;
            else                     gnt_i = 1'b1;
        end else if (req_i) begin
            gnt_i = 1'b1;
        end else if (req_d) begin
            gnt_d = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data access.
// One transaction at a time; the grant is held until mem_ready or timeout.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport: i_* fetch side, d_* data side, err, mem_* memory side
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_WIDTH      = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
    // counter value on the edge that would bring it to TIMEOUT_CYCLES
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state, next_state;
    grant_t                last_grant;
    logic [CNT_WIDTH-1:0]  cnt;

    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  i_done_q, d_done_q, err_q;
    logic [31:0]           i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;

    logic req_i_eff, req_d_eff, gnt_i, gnt_d;
    logic busy, timeout_hit;
    logic take_i, take_d, finish;

    // a request is not re-granted in the cycle its own completion is reported
    assign req_i_eff = bus.i_req & ~i_done_q;
    assign req_d_eff = bus.d_req & ~d_done_q;

    rr_arbiter2 u_rr (
        .req_i      (req_i_eff),
        .req_d      (req_d_eff),
        .last_grant (last_grant),
        .gnt_i      (gnt_i),
        .gnt_d      (gnt_d)
    );

    assign busy        = (state != IDLE);
    // mem_ready on the same edge takes priority over the abort
    assign timeout_hit = TO_EN && busy && !bus.mem_ready && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (gnt_d)      next_state = BUSY_D;
                else if (gnt_i) next_state = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready || timeout_hit) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        take_i = (state == IDLE) && gnt_i;
        take_d = (state == IDLE) && gnt_d;
        finish = busy && (bus.mem_ready || timeout_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= GNT_I;
            cnt         <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            i_done_q <= finish && (state == BUSY_I);
            d_done_q <= finish && (state == BUSY_D);

            if (finish) begin
                err_q <= !bus.mem_ready;
                if (state == BUSY_I) begin
                    if (!bus.mem_ready)    i_rdata_q <= '0;
                    else if (mem_addr_q[2]) i_rdata_q <= bus.mem_rdata[63:32];
                    else                   i_rdata_q <= bus.mem_rdata[31:0];
                end else begin
                    d_rdata_q <= (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
                end
            end

            if (take_i) begin
                mem_addr_q  <= bus.i_addr;
                mem_we_q    <= 1'b0;
                mem_wdata_q <= '0;
                last_grant  <= GNT_I;
                cnt         <= '0;
            end else if (take_d) begin
                mem_addr_q  <= bus.d_addr;
                mem_we_q    <= bus.d_we;
                mem_wdata_q <= bus.d_wdata;
                last_grant  <= GNT_D;
                cnt         <= '0;
            end else if (busy && !bus.mem_ready) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;

endmodule
